// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_redirect_unit_if;
  logic [31:0] I_ADDR;
  logic        I_REQ;
  logic        I_ACK;
  logic [31:0] I_RDATA;

  modport master (output I_ADDR, output I_REQ, input I_ACK, input I_RDATA);
  modport slave  (input I_ADDR, input I_REQ, output I_ACK, output I_RDATA);
endinterface

// File: rtl/fetch_redirect_unit.sv
// PC sequencing and instruction fetch front end: memory handshake, one-entry skid,
// redirect/kill handling. Optional macro BRANCH_MISALIGN_CHECK_EN rejects targets with bit 1 set.
module fetch_redirect_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         BRANCH_TAKEN,
  input  logic [31:0]                  TARGET_PC,
  input  logic                         TRAP_TAKEN,
  input  logic [31:0]                  TRAP_PC,
  input  logic                         STALL,
  fetch_redirect_unit_if.master        imem,
  output logic [31:0]                  INSTR,
  output logic [31:0]                  INSTR_PC,
  output logic                         INSTR_VALID,
  output logic                         FLUSH,
  output logic                         MISALIGNED_TARGET
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_SKID} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_addr;
  logic        r_kill;
  logic [31:0] r_instr, r_instr_pc;
  logic        r_instr_valid;
  logic [31:0] r_skid_instr, r_skid_pc;
  logic        r_flush;

  logic        w_redir_req, w_misalign, w_redirect, w_flush;
  logic [31:0] w_target_raw, w_target;
  logic        w_req, w_req_o, w_ack, w_slot_free;

  // Trap outranks branch; low two target bits never reach the PC.
  assign w_redir_req  = TRAP_TAKEN | BRANCH_TAKEN;
  assign w_target_raw = TRAP_TAKEN ? TRAP_PC : TARGET_PC;
  assign w_target     = w_target_raw & 32'hFFFF_FFFC;

`ifdef BRANCH_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_misalign = w_redir_req & w_target_raw[1];

  always_ff @(posedge CLK) begin
    if (RESET) r_misalign <= 1'b0;
    else       r_misalign <= w_misalign;
  end

  assign MISALIGNED_TARGET = r_misalign;
`else
  assign w_misalign        = 1'b0;
  assign MISALIGNED_TARGET = 1'b0;
`endif

  assign w_redirect  = w_redir_req & ~w_misalign;
  assign w_slot_free = ~r_instr_valid | ~STALL;
  assign w_ack       = imem.I_ACK & w_req_o;
  // A redirect while a kill is already pending only retargets the PC.
  assign w_flush     = w_redirect & ~(r_kill & ~w_ack);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_ISSUE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect) begin
      w_state_nxt = (r_state == ST_WAIT && !w_ack) ? ST_WAIT : ST_ISSUE;
    end else begin
      unique case (r_state)
        ST_ISSUE: if (w_req && !w_ack) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (w_ack) w_state_nxt = (r_kill || w_slot_free) ? ST_ISSUE : ST_SKID;
        ST_SKID:  if (!STALL) w_state_nxt = ST_ISSUE;
        default:  w_state_nxt = ST_ISSUE;
      endcase
    end
  end

  // Output logic; requests are suppressed while reset is held so a late ack is ignored.
  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      ST_ISSUE: w_req = ~STALL | ~r_instr_valid;
      ST_WAIT:  w_req = 1'b1;
      ST_SKID:  w_req = 1'b0;
      default:  w_req = 1'b0;
    endcase
    w_req_o     = w_req & ~RESET;
    imem.I_REQ  = w_req_o;
    imem.I_ADDR = (r_state == ST_WAIT) ? r_addr : r_pc;
  end

  // PC, kill, output slot and skid datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc          <= BOOT_ADDRESS;
      r_addr        <= BOOT_ADDRESS;
      r_kill        <= 1'b0;
      r_instr       <= NOP;
      r_instr_pc    <= BOOT_ADDRESS;
      r_instr_valid <= 1'b0;
      r_skid_instr  <= NOP;
      r_skid_pc     <= BOOT_ADDRESS;
      r_flush       <= 1'b0;
    end else begin
      r_flush <= w_flush;
      if (w_redirect) begin
        r_pc          <= w_target;
        r_instr_valid <= 1'b0;
        r_kill        <= (r_state == ST_WAIT) && !w_ack;
      end else begin
        if (!STALL) r_instr_valid <= 1'b0;
        unique case (r_state)
          ST_ISSUE: begin
            if (w_ack) begin
              r_pc          <= r_pc + 32'd4;
              r_instr       <= imem.I_RDATA;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
            end else if (w_req) begin
              r_addr <= r_pc;
            end
          end
          ST_WAIT: begin
            if (w_ack) begin
              if (r_kill) begin
                r_kill <= 1'b0;
              end else if (w_slot_free) begin
                r_pc          <= r_addr + 32'd4;
                r_instr       <= imem.I_RDATA;
                r_instr_pc    <= r_addr;
                r_instr_valid <= 1'b1;
              end else begin
                r_pc         <= r_addr + 32'd4;
                r_skid_instr <= imem.I_RDATA;
                r_skid_pc    <= r_addr;
              end
            end
          end
          ST_SKID: begin
            if (!STALL) begin
              r_instr       <= r_skid_instr;
              r_instr_pc    <= r_skid_pc;
              r_instr_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign INSTR       = r_instr;
  assign INSTR_PC    = r_instr_pc;
  assign INSTR_VALID = r_instr_valid;
  assign FLUSH       = r_flush;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: memory returns the address as data; consumed
// instructions are checked in order against a queue of expected PCs.
module tb_fetch_redirect_unit;
  logic        CLK = 1'b0;
  logic        RESET, BRANCH_TAKEN, TRAP_TAKEN, STALL;
  logic [31:0] TARGET_PC, TRAP_PC;
  logic [31:0] INSTR, INSTR_PC;
  logic        INSTR_VALID, FLUSH, MISALIGNED_TARGET;
  logic        ack_en, force_ack;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  fetch_redirect_unit_if mif ();
  assign mif.I_ACK   = force_ack | (mif.I_REQ & ack_en);
  assign mif.I_RDATA = mif.I_ADDR;

  fetch_redirect_unit #(.BOOT_ADDRESS(32'h0)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .TARGET_PC         (TARGET_PC),
    .TRAP_TAKEN        (TRAP_TAKEN),
    .TRAP_PC           (TRAP_PC),
    .STALL             (STALL),
    .imem              (mif.master),
    .INSTR             (INSTR),
    .INSTR_PC          (INSTR_PC),
    .INSTR_VALID       (INSTR_VALID),
    .FLUSH             (FLUSH),
    .MISALIGNED_TARGET (MISALIGNED_TARGET)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Decode consumes whenever INSTR_VALID && !STALL
  always @(negedge CLK) begin
    if (!RESET && INSTR_VALID && !STALL) begin
      chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        chk("sb_pc", INSTR_PC, sb_exp);
        chk("sb_instr", INSTR, sb_exp);
      end
    end
  end

  task automatic do_reset();
    RESET = 1'b1; force_ack = 1'b1; ack_en = 1'b1; STALL = 1'b0;
    BRANCH_TAKEN = 1'b0; TRAP_TAKEN = 1'b0; TARGET_PC = '0; TRAP_PC = '0;
    sb_q.delete();
    tick();
    @(negedge CLK);
    chk("rst_req", 32'(mif.I_REQ), 32'd0);
    chk("rst_vld", 32'(INSTR_VALID), 32'd0);
    chk("rst_instr", INSTR, 32'h13);
    chk("rst_ipc", INSTR_PC, 32'h0);
    chk("rst_flush", 32'(FLUSH), 32'd0);
    chk("rst_mis", 32'(MISALIGNED_TARGET), 32'd0);
    tick();
    RESET = 1'b0; force_ack = 1'b0;
  endtask

  initial begin
    // Sequential fetch, zero-wait memory
    do_reset();
    for (int e = 0; e < 5; e++) sb_q.push_back(32'(e * 4));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("seq_addr", mif.I_ADDR, 32'(i * 4));
      if (i == 0) chk("first_vld", 32'(INSTR_VALID), 32'd0);
      tick();
    end
    chk("p1_drain", 32'(sb_q.size()), 32'd0);

    // Branch while waiting on a delayed ack
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h4);
    sb_q.push_back(32'h100); sb_q.push_back(32'h104);
    @(negedge CLK); tick();
    @(negedge CLK); tick();
    ack_en = 1'b0;
    @(negedge CLK);
    chk("w_addr", mif.I_ADDR, 32'h8);
    chk("w_req", 32'(mif.I_REQ), 32'd1);
    tick();
    BRANCH_TAKEN = 1'b1; TARGET_PC = 32'h100;
    @(negedge CLK); chk("w_hold0", mif.I_ADDR, 32'h8); tick();
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("w_hold1", mif.I_ADDR, 32'h8);
    chk("br_flush", 32'(FLUSH), 32'd1);
    chk("br_vld", 32'(INSTR_VALID), 32'd0);
    tick();
    ack_en = 1'b1;
    @(negedge CLK);
    chk("w_hold2", mif.I_ADDR, 32'h8);
    chk("br_flush_off", 32'(FLUSH), 32'd0);
    tick();
    @(negedge CLK); chk("br_addr", mif.I_ADDR, 32'h100); tick();
    @(negedge CLK); tick();
    @(negedge CLK); tick();
    chk("p2_drain", 32'(sb_q.size()), 32'd0);

    // Stall across a pending fetch; stray ack with no request
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
    @(negedge CLK); tick();
    ack_en = 1'b0;
    @(negedge CLK); tick();
    STALL = 1'b1;
    @(negedge CLK);
    chk("st_addr", mif.I_ADDR, 32'h4);
    chk("st_req", 32'(mif.I_REQ), 32'd1);
    chk("st_vld0", 32'(INSTR_VALID), 32'd0);
    tick();
    ack_en = 1'b1;
    @(negedge CLK); tick();
    @(negedge CLK);
    chk("st_noreq", 32'(mif.I_REQ), 32'd0);
    chk("st_vld1", 32'(INSTR_VALID), 32'd1);
    chk("st_ipc", INSTR_PC, 32'h4);
    tick();
    force_ack = 1'b1;
    @(negedge CLK);
    chk("st_noreq2", 32'(mif.I_REQ), 32'd0);
    chk("st_instr", INSTR, 32'h4);
    tick();
    STALL = 1'b0; force_ack = 1'b0;
    @(negedge CLK); chk("st_resume", mif.I_ADDR, 32'h8); tick();
    @(negedge CLK); tick();
    chk("p3_drain", 32'(sb_q.size()), 32'd0);

    // Trap beats branch in the same cycle
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h200); sb_q.push_back(32'h204);
    @(negedge CLK); tick();
    TRAP_TAKEN = 1'b1; TRAP_PC = 32'h200; BRANCH_TAKEN = 1'b1; TARGET_PC = 32'h300;
    @(negedge CLK); tick();
    TRAP_TAKEN = 1'b0; BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("tr_addr", mif.I_ADDR, 32'h200);
    chk("tr_flush", 32'(FLUSH), 32'd1);
    chk("tr_vld", 32'(INSTR_VALID), 32'd0);
    tick();
    @(negedge CLK); chk("tr_flush_off", 32'(FLUSH), 32'd0); tick();
    @(negedge CLK); tick();
    chk("p4_drain", 32'(sb_q.size()), 32'd0);

    // PC wrap, then a target with bit 1 set
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'hFFFF_FFFC); sb_q.push_back(32'h0);
`ifdef BRANCH_MISALIGN_CHECK_EN
    sb_q.push_back(32'h4); sb_q.push_back(32'h8); sb_q.push_back(32'hC);
`else
    sb_q.push_back(32'h100); sb_q.push_back(32'h104);
`endif
    @(negedge CLK); tick();
    BRANCH_TAKEN = 1'b1; TARGET_PC = 32'hFFFF_FFFC;
    @(negedge CLK); tick();
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK); chk("wr_top", mif.I_ADDR, 32'hFFFF_FFFC); tick();
    @(negedge CLK); chk("wr_zero", mif.I_ADDR, 32'h0); tick();
    BRANCH_TAKEN = 1'b1; TARGET_PC = 32'h102;
    @(negedge CLK); tick();
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
`ifdef BRANCH_MISALIGN_CHECK_EN
    chk("ma_addr", mif.I_ADDR, 32'h8);
    chk("ma_flush", 32'(FLUSH), 32'd0);
    chk("ma_flag", 32'(MISALIGNED_TARGET), 32'd1);
`else
    chk("ma_addr", mif.I_ADDR, 32'h100);
    chk("ma_flush", 32'(FLUSH), 32'd1);
    chk("ma_flag", 32'(MISALIGNED_TARGET), 32'd0);
`endif
    tick();
    @(negedge CLK); chk("ma_flag_off", 32'(MISALIGNED_TARGET), 32'd0); tick();
    @(negedge CLK); tick();
    chk("p5_drain", 32'(sb_q.size()), 32'd0);

    // Reset during an outstanding request, with acks arriving under reset
    do_reset();
    ack_en = 1'b0;
    @(negedge CLK); tick();
    do_reset();
    sb_q.push_back(32'h0);
    @(negedge CLK);
    chk("rw_addr", mif.I_ADDR, 32'h0);
    chk("rw_req", 32'(mif.I_REQ), 32'd1);
    tick();
    @(negedge CLK); tick();
    chk("p6_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Program-counter and instruction-fetch front end of Steel Core.
- Consumes the branch-decision result (BRANCH_TAKEN plus the computed target) and the trap redirect, and keeps the PC sequence.
- Runs the request/acknowledge handshake to instruction memory and presents one fetched instruction at a time, with its PC, to decode.
- Handles stalls with a one-entry skid buffer and discards wrong-path fetches after a redirect.

Parameters:
BOOT_ADDRESS, 32'h00000000, PC value loaded on reset.

Ports:
CLK  input  1  core clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
BRANCH_TAKEN  input  1  branch/jump redirect request from branch decision unit
TARGET_PC  input  32  branch/jump target; valid when BRANCH_TAKEN=1
TRAP_TAKEN  input  1  trap/mret redirect request
TRAP_PC  input  32  trap target; valid when TRAP_TAKEN=1
STALL  input  1  decode cannot accept INSTR this cycle
I_ADDR  output  32  instruction memory address
I_REQ  output  1  fetch request
I_ACK  input  1  memory accepted request; I_RDATA valid this cycle
I_RDATA  input  32  fetched instruction word
INSTR  output  32  instruction to decode
INSTR_PC  output  32  PC of INSTR
INSTR_VALID  output  1  INSTR/INSTR_PC valid
FLUSH  output  1  registered one-cycle pulse: a redirect occurred last cycle
MISALIGNED_TARGET  output  1  see Optional Feature; constant 0 when feature off

Behaviour:
- Reset state: pc=BOOT_ADDRESS; state=ISSUE; I_REQ=0; INSTR_VALID=0; INSTR=32'h00000013 (NOP); INSTR_PC=BOOT_ADDRESS; FLUSH=0; kill=0; skid empty; MISALIGNED_TARGET=0.
- Reset takes priority over all other inputs, including mid-request. An outstanding request is abandoned, and any I_ACK in the cycle after reset is ignored.
- Redirect priority: RESET > TRAP_TAKEN > BRANCH_TAKEN > STALL > sequential. Redirect target = TRAP_PC if TRAP_TAKEN, else TARGET_PC.
- Memory handshake:
  - Once I_REQ=1, I_REQ and I_ADDR stay stable until the cycle I_ACK=1.
  - I_ACK while I_REQ=0 is ignored.
  - Zero-wait memory: I_ACK in the same cycle I_REQ rises.
  - Throughput: one instruction per cycle with zero-wait memory and no stall.
- FSM states: ISSUE, WAIT, SKID.
  - ISSUE:
    - I_REQ = !STALL || !INSTR_VALID, with I_ADDR=pc.
    - On I_ACK without redirect: pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0). Load INSTR/INSTR_PC/INSTR_VALID=1 if the output slot is free or being consumed; stay in ISSUE.
    - I_REQ=1 without I_ACK -> WAIT.
  - WAIT:
    - I_REQ=1 with held I_ADDR.
    - On I_ACK: if kill=1, discard data, kill<=0, -> ISSUE.
    - Else if output slot free (INSTR_VALID=0 or STALL=0): load output, pc+=4, -> ISSUE.
    - Else: store word+PC in skid, pc+=4, -> SKID.
  - SKID:
    - I_REQ=0.
    - When STALL=0: output<=skid, skid empty, -> ISSUE.
- Output consumption: INSTR_VALID=1 with STALL=0 at a clock edge means decode consumed the instruction. If no new word loads, INSTR_VALID<=0.
- Redirect (any state, no reset):
  - pc<=target; INSTR_VALID<=0; skid cleared; FLUSH<=1 next cycle.
  - In WAIT without I_ACK: kill<=1, stay WAIT at the old address.
  - Otherwise -> ISSUE. A same-cycle I_ACK is discarded.
  - Redirect overrides STALL.
- A redirect in the cycle kill is already set updates pc only; kill stays 1.
- pc bits [1:0]: the target is used with bits [1:0] forced to 0 (feature off).

Optional Feature:
- Macro: BRANCH_MISALIGN_CHECK_EN.
- Defined: a redirect whose target has bit 1 set is not taken. pc is unchanged, no flush, and MISALIGNED_TARGET=1 for exactly one cycle (registered) for the trap logic. Target bit 0 is always cleared.
- Undefined: target bits [1:0] forced to 0; MISALIGNED_TARGET tied to 0.

Test Plan:
- Reset, zero-wait memory returning addr as data, STALL=0 -> I_ADDR 0,4,8,...; INSTR_PC 0,4,8 on consecutive cycles; first INSTR_VALID cycle after reset release +1.
- BRANCH_TAKEN=1, TARGET_PC=0x100 while WAIT (I_ACK delayed 3 cycles) -> I_ADDR held at old value until ack; that word never shows INSTR_VALID; next I_ADDR=0x100; FLUSH pulses once.
- STALL=1 for 4 cycles during WAIT, ack arrives -> INSTR held; second word in skid; I_REQ=0; after STALL=0 the two words appear in order with no gap or loss.
- TRAP_TAKEN=1 (TRAP_PC=0x200) and BRANCH_TAKEN=1 (0x300) same cycle -> next I_ADDR=0x200.
- pc=0xFFFFFFFC sequential fetch -> next I_ADDR=0x00000000.
- With BRANCH_MISALIGN_CHECK_EN, TARGET_PC=0x102 -> MISALIGNED_TARGET=1 one cycle, sequential fetch continues, FLUSH=0. Without the macro -> fetch at 0x100.
